bcd_scan_display: RTL and testbench

- Multiplexed 7-segment display driver that sits directly downstream of a cascade of 4-bit decade up/down counter stages.
- It consumes the BCD digit outputs of the cascade and keeps a stable snapshot of them, so the counters can keep ticking while the display holds its value.
- It scans one digit at a time at a prescaled rate, decodes BCD to segments and optionally blanks leading zeros.

---
 rtl/bcd_scan_display.sv | 152 +++++++++++++++
 tb/tb_bcd_scan_display.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_display.sv
// Multiplexed 7-segment driver for a BCD counter cascade: snapshot latch,
// prescaled digit scan, BCD-to-segment decode and leading-zero blanking.
module bcd_scan_display #(
    parameter int NDIG     = 4,
    parameter int PRESCALE = 1000
) (
    input  logic              CLK,
    input  logic              CDN,
    input  logic [4*NDIG-1:0] BCD,
    input  logic [NDIG-1:0]   DP,
    input  logic              LD,
    input  logic              EN,
    input  logic              LZB,
    output logic [6:0]        SEG,
    output logic              SEGDP,
    output logic [NDIG-1:0]   AN,
    output logic              SCAN_TC
);

    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [15:0]   PRE_LAST = 16'(PRESCALE - 1);

    logic [4*NDIG-1:0] snap_q, snap_d;
    logic [NDIG-1:0]   dp_q, dp_d;
    logic [15:0]       pre_q, pre_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [6:0]        seg_q, seg_d;
    logic              segdp_q, segdp_d;
    logic [NDIG-1:0]   an_q, an_d;
    logic              tc_q, tc_d;

    logic [NDIG-1:0]   lead_zero;
    logic              above_zero;
    logic [3:0]        cur_digit;
    logic              cur_dp;
    logic              cur_blank;
    logic [NDIG-1:0]   cur_sel;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    // Snapshot latch: loads regardless of EN so the counters can be frozen any time.
    always_comb begin
        snap_d = snap_q;
        dp_d   = dp_q;
        if (LD) begin
            snap_d = BCD;
            dp_d   = DP;
        end
    end

    // Prescaler and digit index only move while enabled.
    always_comb begin
        pre_d = pre_q;
        idx_d = idx_q;
        tc_d  = 1'b0;
        if (EN) begin
            if (pre_q == PRE_LAST) begin
                pre_d = 16'd0;
                if (idx_q == IDX_LAST) begin
                    idx_d = '0;
                    tc_d  = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end else begin
                pre_d = pre_q + 16'd1;
            end
        end
    end

    // A digit is a leading zero when it and every more significant digit are 0.
    always_comb begin
        lead_zero  = '0;
        above_zero = 1'b1;
        for (int i = NDIG - 1; i > 0; i--) begin
            above_zero   = above_zero & (snap_q[4*i +: 4] == 4'd0);
            lead_zero[i] = above_zero;
        end
    end

    always_comb begin
        cur_digit = 4'd0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_sel   = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx_q == IW'(i)) begin
                cur_digit  = snap_q[4*i +: 4];
                cur_dp     = dp_q[i];
                cur_blank  = LZB & lead_zero[i];
                cur_sel[i] = 1'b1;
            end
        end
    end

    always_comb begin
        seg_d   = 7'h00;
        segdp_d = 1'b0;
        an_d    = '0;
        if (EN) begin
            seg_d   = cur_blank ? 7'h00 : decode(cur_digit);
            segdp_d = cur_dp;
            an_d    = cur_sel;
        end
    end

    always_ff @(posedge CLK or negedge CDN) begin
        if (!CDN) begin
            snap_q  <= '0;
            dp_q    <= '0;
            pre_q   <= 16'd0;
            idx_q   <= '0;
            seg_q   <= 7'h00;
            segdp_q <= 1'b0;
            an_q    <= '0;
            tc_q    <= 1'b0;
        end else begin
            snap_q  <= snap_d;
            dp_q    <= dp_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            segdp_q <= segdp_d;
            an_q    <= an_d;
            tc_q    <= tc_d;
        end
    end

    assign SEG     = seg_q;
    assign SEGDP   = segdp_q;
    assign AN      = an_q;
    assign SCAN_TC = tc_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Bench for bcd_scan_display: behavioural scan model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_bcd_scan_display;
    localparam int NDIG     = 4;
    localparam int PRESCALE = 4;

    logic        CLK = 1'b0;
    logic        CDN = 1'b1;
    logic [15:0] BCD = 16'h0000;
    logic [3:0]  DP  = 4'b0000;
    logic        LD  = 1'b0;
    logic        EN  = 1'b0;
    logic        LZB = 1'b0;
    logic [6:0]  SEG;
    logic        SEGDP;
    logic [3:0]  AN;
    logic        SCAN_TC;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    always #5 CLK = ~CLK;

    bcd_scan_display #(.NDIG(NDIG), .PRESCALE(PRESCALE)) dut (
        .CLK(CLK), .CDN(CDN), .BCD(BCD), .DP(DP), .LD(LD), .EN(EN), .LZB(LZB),
        .SEG(SEG), .SEGDP(SEGDP), .AN(AN), .SCAN_TC(SCAN_TC)
    );

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    // Behavioural model: digits as integers, scan position as dwell count and digit number.
    int         m_dig[NDIG];
    bit         m_dp[NDIG];
    int         m_pre = 0;
    int         m_idx = 0;
    logic [6:0] e_seg = 7'h00;
    logic       e_segdp = 1'b0;
    logic [3:0] e_an = 4'b0000;
    logic       e_tc = 1'b0;

    always @(posedge CLK or negedge CDN) begin
        bit lead;
        if (!CDN) begin
            m_pre = 0;
            m_idx = 0;
            for (int j = 0; j < NDIG; j++) begin
                m_dig[j] = 0;
                m_dp[j]  = 1'b0;
            end
            e_seg = 7'h00; e_segdp = 1'b0; e_an = 4'b0000; e_tc = 1'b0;
        end else begin
            if (EN) begin
                lead = LZB && (m_idx > 0);
                for (int j = m_idx; j < NDIG; j++)
                    if (m_dig[j] != 0) lead = 1'b0;
                e_an    = 4'(1 << m_idx);
                e_seg   = lead ? 7'h00 : seg_of(m_dig[m_idx]);
                e_segdp = m_dp[m_idx];
                e_tc    = (m_pre == PRESCALE - 1) && (m_idx == NDIG - 1);
                m_pre++;
                if (m_pre == PRESCALE) begin
                    m_pre = 0;
                    m_idx = (m_idx + 1) % NDIG;
                end
            end else begin
                e_seg = 7'h00; e_segdp = 1'b0; e_an = 4'b0000; e_tc = 1'b0;
            end
            if (LD) begin
                for (int j = 0; j < NDIG; j++) begin
                    m_dig[j] = int'(BCD[4*j +: 4]);
                    m_dp[j]  = DP[j];
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_on) begin
            tests++;
            if (SEG !== e_seg || SEGDP !== e_segdp || AN !== e_an || SCAN_TC !== e_tc) begin
                fails++;
                $display("FAIL model t=%0t got SEG=%h SEGDP=%b AN=%b TC=%b want SEG=%h SEGDP=%b AN=%b TC=%b",
                         $time, SEG, SEGDP, AN, SCAN_TC, e_seg, e_segdp, e_an, e_tc);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic load(input logic [15:0] b, input logic [3:0] d);
        BCD = b; DP = d; LD = 1'b1;
        cyc(1);
        LD = 1'b0;
        cyc(1);
    endtask

    task automatic wait_an(input int dig, input string name);
        int k;
        k = 0;
        while (AN !== 4'(1 << dig) && k < 64) begin
            cyc(1);
            k++;
        end
        if (k >= 64) begin
            tests++;
            fails++;
            $display("FAIL %s timeout waiting for AN digit %0d, AN=%b", name, dig, AN);
        end
    endtask

    task automatic show(input int dig, input logic [6:0] s, input logic d, input string name);
        wait_an(dig, name);
        chk({name, "_seg"}, 32'(SEG), 32'(s));
        chk({name, "_dp"}, 32'(SEGDP), 32'(d));
    endtask

    function automatic logic [3:0] rnd_dig();
        int r;
        r = $urandom_range(0, 9);
        if (r < 4) return 4'd0;
        else if (r < 8) return 4'($urandom_range(1, 9));
        else return 4'($urandom_range(10, 15));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] nib;
        #2 CDN = 1'b0;
        cyc(2);
        chk("rst_an", 32'(AN), 32'h0);
        chk("rst_seg", 32'(SEG), 32'h0);
        chk("rst_dp", 32'(SEGDP), 32'h0);
        chk("rst_tc", 32'(SCAN_TC), 32'h0);
        chk_on = 1'b1;
        CDN = 1'b1;

        // Scan sequence and wrap pulse
        BCD = 16'h1234; DP = 4'b0000; LD = 1'b1;
        cyc(1);
        LD = 1'b0; EN = 1'b1;
        cyc(1);
        chk("t1_an0", 32'(AN), 32'h1); chk("t1_seg0", 32'(SEG), 32'h66); chk("t1_tc0", 32'(SCAN_TC), 32'h0);
        cyc(4);
        chk("t1_an1", 32'(AN), 32'h2); chk("t1_seg1", 32'(SEG), 32'h4F);
        cyc(4);
        chk("t1_an2", 32'(AN), 32'h4); chk("t1_seg2", 32'(SEG), 32'h5B);
        cyc(4);
        chk("t1_an3", 32'(AN), 32'h8); chk("t1_seg3", 32'(SEG), 32'h06); chk("t1_tc3", 32'(SCAN_TC), 32'h0);
        cyc(3);
        chk("t1_tc_wrap", 32'(SCAN_TC), 32'h1); chk("t1_an_wrap", 32'(AN), 32'h8);
        cyc(1);
        chk("t1_tc_after", 32'(SCAN_TC), 32'h0); chk("t1_an_back0", 32'(AN), 32'h1);
        cyc(15);
        chk("t1_tc_period", 32'(SCAN_TC), 32'h1);

        // Leading-zero blanking
        LZB = 1'b1;
        load(16'h0040, 4'b0001);
        show(3, 7'h00, 1'b0, "t2_d3"); show(2, 7'h00, 1'b0, "t2_d2");
        show(1, 7'h66, 1'b0, "t2_d1"); show(0, 7'h3F, 1'b1, "t2_d0");
        load(16'h0000, 4'b0000);
        show(3, 7'h00, 1'b0, "t2z_d3"); show(2, 7'h00, 1'b0, "t2z_d2");
        show(1, 7'h00, 1'b0, "t2z_d1"); show(0, 7'h3F, 1'b0, "t2z_d0");
        load(16'h0A05, 4'b0000);
        show(3, 7'h00, 1'b0, "t3_d3"); show(2, 7'h40, 1'b0, "t3_d2");
        show(1, 7'h3F, 1'b0, "t3_d1"); show(0, 7'h6D, 1'b0, "t3_d0");

        // Pause mid-dwell at digit 2
        wait_an(2, "t4_sync");
        cyc(1);
        EN = 1'b0;
        cyc(1);
        chk("t4_an_off", 32'(AN), 32'h0); chk("t4_seg_off", 32'(SEG), 32'h0);
        chk("t4_tc_off", 32'(SCAN_TC), 32'h0);
        cyc(9);
        chk("t4_an_still_off", 32'(AN), 32'h0);
        EN = 1'b1;
        cyc(1);
        chk("t4_resume_an", 32'(AN), 32'h4); chk("t4_resume_seg", 32'(SEG), 32'h40);
        cyc(1);
        chk("t4_resume_an2", 32'(AN), 32'h4);
        cyc(1);
        chk("t4_next_an", 32'(AN), 32'h8); chk("t4_next_seg", 32'(SEG), 32'h00);

        // Transparent snapshot with LD held high
        LZB = 1'b0; DP = 4'b0000; LD = 1'b1;
        for (int v = 0; v < 10; v++) begin
            nib = 4'(v);
            BCD = {nib, nib, nib, nib};
            cyc(1);
            if (v > 0) chk("t5_track", 32'(SEG), 32'(seg_of(v - 1)));
        end
        LD = 1'b0; BCD = 16'h1357;
        for (int k = 0; k < 6; k++) begin
            cyc(1);
            chk("t5_frozen", 32'(SEG), 32'h6F);
        end

        // Asynchronous reset mid-dwell
        wait_an(3, "t6_sync");
        cyc(1);
        chk("t6_pre_seg", 32'(SEG), 32'h6F);
        #3 CDN = 1'b0;
        #1;
        chk("t6_async_an", 32'(AN), 32'h0); chk("t6_async_seg", 32'(SEG), 32'h0);
        chk("t6_async_dp", 32'(SEGDP), 32'h0); chk("t6_async_tc", 32'(SCAN_TC), 32'h0);
        cyc(2);
        CDN = 1'b1; LZB = 1'b1; EN = 1'b1;
        cyc(1);
        chk("t6_first_an", 32'(AN), 32'h1); chk("t6_first_seg", 32'(SEG), 32'h3F);
        cyc(4);
        chk("t6_second_an", 32'(AN), 32'h2); chk("t6_second_seg", 32'(SEG), 32'h00);

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            EN  = ($urandom_range(0, 7) != 0);
            LD  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) LZB = ~LZB;
            BCD = {rnd_dig(), rnd_dig(), rnd_dig(), rnd_dig()};
            DP  = 4'($urandom_range(0, 15));
            if (c == 700) begin
                #2 CDN = 1'b0;
                #4 CDN = 1'b1;
            end
            cyc(1);
        end

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
